// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data (via serializer), optional parity, stop.
// Optional second stop bit: define UART_TX_TWO_STOP_EN.
`timescale 1ns/1ps
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_type,
  input  logic              baud_tick,
  input  logic              ser_done,
  output logic              ser_load,
  output logic              ser_en,
  output logic [1:0]        mux_sel,
  output logic              par_bit,
  output logic              busy,
  output logic              tx_done,
  output logic              frame_err
);

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_IDLE  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             par_en_q;
  logic             ser_load_q;
  logic [1:0]       mux_sel_q;
  logic             par_bit_q;
  logic             busy_q;
  logic             tx_done_q;
  logic             frame_err_q;
  logic             last_stop_c;
  logic             accept_c;

  // The final stop state is where a frame closes and a new byte may be taken.
`ifdef UART_TX_TWO_STOP_EN
  assign last_stop_c = (state_q == STOP2);
`else
  assign last_stop_c = (state_q == STOP);
`endif

  // Accept in IDLE, or back-to-back on the tick that ends the stop bit.
  assign accept_c = data_valid & ((state_q == IDLE) | (last_stop_c & baud_tick));

  // Shift enable follows the tick directly so the serializer moves on the same edge.
  assign ser_en = (state_q == DATA) & baud_tick;

  // Frame sequencer with registered controls; accept overrides the stop-exit values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      par_en_q    <= 1'b0;
      ser_load_q  <= 1'b0;
      mux_sel_q   <= SEL_IDLE;
      par_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ser_load_q <= 1'b0;
      tx_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          mux_sel_q <= SEL_IDLE;
          busy_q    <= 1'b0;
        end
        START: begin
          if (baud_tick) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            mux_sel_q <= SEL_DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (ser_done) begin
              state_q   <= par_en_q ? PARITY : STOP;
              mux_sel_q <= par_en_q ? SEL_PAR : SEL_IDLE;
            end else if (bit_cnt_q == LAST_BIT) begin
              frame_err_q <= 1'b1;
              state_q     <= STOP;
              mux_sel_q   <= SEL_IDLE;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state_q   <= STOP;
            mux_sel_q <= SEL_IDLE;
          end
        end
`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          if (baud_tick) begin
            state_q <= STOP2;
          end
        end
        STOP2: begin
          if (baud_tick) begin
            state_q   <= IDLE;
            tx_done_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
`else
        STOP: begin
          if (baud_tick) begin
            state_q   <= IDLE;
            tx_done_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
`endif
        default: begin
          state_q   <= IDLE;
          mux_sel_q <= SEL_IDLE;
          busy_q    <= 1'b0;
        end
      endcase
      if (accept_c) begin
        par_bit_q  <= (^data_in) ^ par_type;
        par_en_q   <= par_en;
        ser_load_q <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= START;
        mux_sel_q  <= SEL_START;
      end
    end
  end

  assign ser_load  = ser_load_q;
  assign mux_sel   = mux_sel_q;
  assign par_bit   = par_bit_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: per-frame expectations popped on ser_load / tx_done.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid, par_en, par_type, baud_tick, ser_done;
  logic       ser_load, ser_en, par_bit, busy, tx_done, frame_err;
  logic [1:0] mux_sel;

  logic [3:0] tick_cnt = 4'd0;
  logic [3:0] ser_cnt  = 4'd0;
  logic       fault_mode, ser_extra;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         ndata;
    int         npar;
    logic       ferr;
    logic       b2b;
    logic       par_done;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic in_frame;
  int   n_start, n_data, n_par, n_stop, n_en;
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_tx_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .par_en(par_en), .par_type(par_type), .baud_tick(baud_tick), .ser_done(ser_done),
    .ser_load(ser_load), .ser_en(ser_en), .mux_sel(mux_sel), .par_bit(par_bit),
    .busy(busy), .tx_done(tx_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Baud generator: one-clock tick every 16 clocks.
  always @(posedge clk) tick_cnt <= tick_cnt + 4'd1;
  assign baud_tick = (tick_cnt == 4'hF);

  // Serializer model: ser_done while the 8th bit is on the line, unless faulted.
  always @(posedge clk) begin
    if (!rst || ser_load) ser_cnt <= 4'd0;
    else if (ser_en)      ser_cnt <= ser_cnt + 4'd1;
  end
  assign ser_done = ((ser_cnt == 4'd7) & ~fault_mode) | ser_extra;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Monitor: frame close first, then new load, then per-tick accounting.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      in_frame = 1'b0;
      n_start = 0; n_data = 0; n_par = 0; n_stop = 0; n_en = 0;
    end else begin
      if (tx_done) begin
        if (!in_frame) chk("unexpected_tx_done", 32'd1, 32'd0);
        else begin
          chk("start_periods", n_start, 1);
          chk("data_periods", n_data, cur.ndata);
          chk("par_periods", n_par, cur.npar);
          chk("stop_periods", n_stop, NSTOP);
          chk("ser_en_pulses", n_en, cur.ndata);
          chk("frame_err_at_done", frame_err, cur.ferr);
          chk("busy_at_done", busy, cur.b2b);
          chk("load_at_done", ser_load, cur.b2b);
          chk("par_bit_at_done", par_bit, cur.par_done);
        end
        in_frame = 1'b0;
      end
      if (ser_load) begin
        if (sb.size() == 0) chk("unexpected_ser_load", 32'd1, 32'd0);
        else begin
          cur = sb.pop_front();
          chk("load_data", data_in, cur.data);
          chk("load_par_bit", par_bit, cur.par);
          chk("load_busy", busy, 1);
          in_frame = 1'b1;
          n_start = 0; n_data = 0; n_par = 0; n_stop = 0; n_en = 0;
        end
      end
      if (in_frame && baud_tick) begin
        case (mux_sel)
          2'b00:   n_start++;
          2'b10:   n_data++;
          2'b11:   n_par++;
          default: n_stop++;
        endcase
      end
      if (in_frame && ser_en) n_en++;
    end
  end

  // Bounded wait at negedge: 0 ser_load, 1 tx_done, 2 mux DATA, 3 mux PARITY.
  task automatic wait_ev(input int which, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((which == 0 && ser_load) || (which == 1 && tx_done) ||
          (which == 2 && mux_sel == 2'b10) || (which == 3 && mux_sel == 2'b11)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL timeout_%s: event not seen within 600 cycles", nm);
    end
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input exp_t e);
    sb.push_back(e);
    data_in = d; par_en = pe; par_type = pt; data_valid = 1'b1;
    wait_ev(0, "load");
    data_valid = 1'b0;
    wait_ev(1, "done");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; data_in = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_type = 1'b0;
    fault_mode = 1'b0; ser_extra = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ser_load", ser_load, 0);
    chk("rst_mux_sel", mux_sel, 2'b01);
    chk("rst_par_bit", par_bit, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_frame_err", frame_err, 0);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;

    // 0x4B has four ones: no parity, then even (0), then odd (1).
    e = '{8'h4B, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0};
    send(8'h4B, 1'b0, 1'b0, e);

    // Even parity, with ignore-rule disturbances while in PARITY.
    e = '{8'h4B, 1'b0, 8, 1, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    data_in = 8'h4B; par_en = 1'b1; par_type = 1'b0; data_valid = 1'b1;
    wait_ev(0, "load_even");
    data_valid = 1'b0;
    wait_ev(3, "parity");
    data_valid = 1'b1; par_en = 1'b0; par_type = 1'b1; data_in = 8'hFF; ser_extra = 1'b1;
    @(negedge clk); #2;
    data_valid = 1'b0; ser_extra = 1'b0;
    @(negedge clk); #2;
    data_valid = 1'b1;
    @(negedge clk); #2;
    data_valid = 1'b0;
    wait_ev(1, "done_even");

    e = '{8'h4B, 1'b1, 8, 1, 1'b0, 1'b0, 1'b1};
    send(8'h4B, 1'b1, 1'b1, e);

    // Back-to-back: 0xA5 odd parity (1), then 0x3C no parity even type (0).
    e = '{8'hA5, 1'b1, 8, 1, 1'b0, 1'b1, 1'b0};
    sb.push_back(e);
    data_in = 8'hA5; par_en = 1'b1; par_type = 1'b1; data_valid = 1'b1;
    wait_ev(0, "load_b2b1");
    e = '{8'h3C, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    data_in = 8'h3C; par_en = 1'b0; par_type = 1'b0;
    wait_ev(0, "load_b2b2");
    data_valid = 1'b0;
    wait_ev(1, "done_b2b2");

    // Serializer fault: 0x81 (two ones) -> frame_err, then sticky through 0x0F odd (1).
    fault_mode = 1'b1;
    e = '{8'h81, 1'b0, 8, 0, 1'b1, 1'b0, 1'b0};
    send(8'h81, 1'b0, 1'b0, e);
    fault_mode = 1'b0;
    e = '{8'h0F, 1'b1, 8, 1, 1'b1, 1'b0, 1'b1};
    send(8'h0F, 1'b1, 1'b1, e);

    // Reset mid-frame during DATA.
    e = '{8'h4B, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    data_in = 8'h4B; par_en = 1'b0; par_type = 1'b0; data_valid = 1'b1;
    wait_ev(0, "load_abort");
    data_valid = 1'b0;
    wait_ev(2, "data_abort");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mux_sel", mux_sel, 2'b01);
    chk("midrst_busy", busy, 0);
    chk("midrst_ser_en", ser_en, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_tx_done", tx_done, 0);
    sb.delete();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;

    // Recovery frame after reset: frame_err cleared.
    e = '{8'h4B, 1'b0, 8, 0, 1'b0, 1'b0, 1'b0};
    send(8'h4B, 1'b0, 1'b0, e);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
